// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Parametrised pipeline stage register with valid/ready
//               handshake, two-entry skid buffer and flush. Optional
//               saturating stall counter enabled by PIPE_STAGE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main;
    logic                w_main_from_skid;
    logic                w_load_skid;

    // The counter width is only meaningful with the stall counter, but a
    // nonsensical value is rejected in every build.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_stage_skid: CNT_W must be at least 1");
    end

    // Ready depends only on registered state (and reset), never on out_ready.
    assign in_ready   = (r_state != ST_FULL) & ~rst;
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturates at all-ones; flush deliberately leaves the count intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Generic parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer and flush. It replaces the fixed per-boundary stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a packed bundle of arbitrary width. It supports back-pressure (stall) and bubble insertion (flush) at full throughput. In_ready is a pure function of state, so ready never forms a combinational path from out_ready to in_ready.

## Interface
Parameters:
- DATA_W, 32, width of the packed stage bundle (pc, pc4, inst, control, operands, ...)
- RST_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset
- CNT_W, 16, width of the stall counter (only with PIPE_STAGE_STALL_CNT_EN)

Ports:
- clk  in  1  stage clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries (branch/jump/exception squash)
- in_valid  in  1  upstream stage holds a valid bundle
- in_ready  out  1  this stage accepts a bundle this cycle
- in_data  in  DATA_W  upstream bundle
- out_valid  out  1  out_data is a valid bundle
- out_ready  in  1  downstream stage accepts out_data this cycle
- out_data  out  DATA_W  registered bundle to downstream
- stall_cnt  out  CNT_W  saturating stall-cycle count (only with PIPE_STAGE_STALL_CNT_EN)

## Operation
- Storage: main register M (drives out_data) and skid register S. State: EMPTY, ONE (M valid), FULL (M and S valid); 2-bit encoding.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL) & ~rst. out_valid = (state != EMPTY).
- EMPTY: in_fire -> M<=in_data, ONE.
- ONE: in_fire & out_fire -> M<=in_data, ONE. in_fire only -> S<=in_data, FULL. out_fire only -> EMPTY. Neither -> hold.
- FULL: out_fire -> M<=S, ONE. Otherwise hold. No input is accepted in FULL.
- Ordering is strictly FIFO. No bundle is duplicated or lost except by flush.
- flush has priority over all handshakes. Next state is EMPTY. A bundle offered with in_fire in the flush cycle is dropped. An out_fire in the flush cycle still counts as delivered downstream. M and S data are not cleared.
- rst has priority over flush. state<=EMPTY, M<=RST_VAL, S<=RST_VAL.
- out_data changes only when M is loaded; it holds its last value in EMPTY.
- in_valid and in_data are don't-care when in_ready=0. Upstream must hold in_data stable while in_valid & ~in_ready.

## Timing
- Latency 1 cycle: a bundle accepted at edge N appears on out_data/out_valid after edge N.
- Throughput is 1 bundle/cycle sustained with out_ready=1.
- Stall absorption: after out_ready drops, one more bundle is accepted (into S). in_ready falls the cycle after that.
- Ready release: FULL plus out_fire at edge N makes in_ready=1 after edge N.
- Reset values after the first clk edge with rst=1: out_valid=0, out_data=RST_VAL, stall_cnt=0. in_ready=0 while rst=1 and 1 in the first cycle after rst falls.
- Flush with rst=0 at edge N: out_valid=0 and in_ready=1 after edge N.

## Configuration
- PIPE_STAGE_STALL_CNT_EN defined:
  - stall_cnt port and counter exist.
  - The counter increments each cycle with out_valid & ~out_ready & ~flush.
  - It saturates at all-ones and is cleared only by rst, not by flush.
- PIPE_STAGE_STALL_CNT_EN undefined:
  - The stall_cnt port and counter logic are absent.
  - The CNT_W parameter is unused.
  - All other behaviour is identical.

## Test plan
- Reset then stream: rst 2 cycles, then in_valid=1 with data 0x100,0x104,0x108 and out_ready=1 -> out_data 0x100,0x104,0x108 on the three consecutive cycles after each acceptance; in_ready stays 1.
- Back-pressure: hold out_ready=0 while streaming 0xA,0xB,0xC -> 0xA in M, 0xB in S, in_ready=0, 0xC held upstream; raise out_ready -> outputs 0xA,0xB,0xC in order, none lost or duplicated.
- Flush in FULL: FULL with 0x1,0x2, assert flush with in_valid=1 (data 0x3) -> next cycle out_valid=0 and in_ready=1; 0x1, 0x2 and 0x3 never appear.
- Reset mid-operation: FULL with stall, assert rst for 1 cycle -> out_valid=0, out_data=RST_VAL, in_ready=0 during rst, 1 afterwards.
- Random ready/valid, 10,000 cycles at DATA_W=97 against a scoreboard queue -> exact in-order match; in_ready never depends combinationally on out_ready.
- With PIPE_STAGE_STALL_CNT_EN and CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays; a flush does not clear it, rst clears it to 0.
